// File: rtl/accelerator_pkg.sv
// -----------------------------------------------------------------------------
// accelerator_pkg
// Datapath-wide constants shared by the accelerator blocks.
// -----------------------------------------------------------------------------
package accelerator_pkg;
    localparam int          ACC_DATA_WIDTH = 16;
    // Value driven onto an idle data bus.
    localparam logic [15:0] EMPTY_DATA     = 16'h0000;
endpackage

// File: rtl/buffer_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// buffer_arbiter_pkg
// One-hot arbiter state encoding, its bit indices, and the round-robin
// pointer advance helper.
// -----------------------------------------------------------------------------
package buffer_arbiter_pkg;
    localparam int ARB_B  = 0;
    localparam int HOLD_B = 1;

    typedef enum logic [1:0] {
        ST_ARB  = 2'b01,   // no owner
        ST_HOLD = 2'b10    // owner granted, tenure counting
    } buffer_arbiter_state_t;

    // Pointer that follows a grant to requester idx: (idx + 1) mod n.
    function automatic int next_ptr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/single_port_ram_pkg.sv
// -----------------------------------------------------------------------------
// single_port_ram_pkg
// Control-pin encodings of the single-port RAM buffer macro. The macro uses
// active-low chip select and output enable, and an active-high write request.
// -----------------------------------------------------------------------------
package single_port_ram_pkg;
    localparam logic CS_EN      = 1'b0;
    localparam logic CS_DIS     = 1'b1;
    localparam logic OE_EN      = 1'b0;
    localparam logic OE_DIS     = 1'b1;
    localparam logic WREQ_WRITE = 1'b1;
    localparam logic WREQ_DIS   = 1'b0;
endpackage

// File: rtl/buffer_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational winner selection for buffer_arbiter.
//   request : per-requester request vector
//   pointer : round-robin start index (search ascends from here with wrap)
//   exclude : requesters removed from this arbitration
//   winner  : one-hot winner (zero when nothing is eligible)
//   valid   : a winner exists
// Build option BUFFER_ARB_FIXED_PRIO_EN: lowest requesting index always wins;
// pointer and exclude are ignored so the lowest index may win again.
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [IDW-1:0]     pointer,
    input  logic [NUM_REQ-1:0] exclude,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

`ifdef BUFFER_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^{pointer, exclude};

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && request[i]) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end
`else
    logic [NUM_REQ-1:0] eligible;
    logic [IDW-1:0]     idx;

    assign eligible = request & ~exclude;

    // Walk NUM_REQ positions starting at pointer; first eligible one wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(pointer) + k) % NUM_REQ);
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/buffer_arbiter.sv
// -----------------------------------------------------------------------------
// buffer_arbiter
// Shares one single-port RAM buffer among NUM_REQ producers. One requester at
// a time owns the buffer for at most BURST_SIZE cycles; the owner's RAM pins
// are muxed onto the buffer and read data is broadcast to everyone.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_request          per-requester request
//   req_grant            registered one-hot grant
//   req_cs/oe/W_req      per-requester RAM controls
//   req_addr, req_W_data packed per-requester address / write data
//   req_R_data           buffer read data broadcast
//   buffer_*             RAM-side pins
//   busy, grant_id       ownership status (grant_id valid when busy)
//   dbg_state            current one-hot FSM state
//
// Handshake: a requester holds req_request high and may drive the RAM only
// while its req_grant is high; the grant follows a high request one edge
// later and drops on the edge after the request falls or the tenure expires.
//
// Build option BUFFER_ARB_FIXED_PRIO_EN: fixed-priority selection instead of
// round-robin (tenure limit unchanged).
// -----------------------------------------------------------------------------
module buffer_arbiter
    import buffer_arbiter_pkg::*;
    import single_port_ram_pkg::*;
    import accelerator_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int BURST_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_REQ-1:0]               req_request,
    output logic [NUM_REQ-1:0]               req_grant,
    input  logic [NUM_REQ-1:0]               req_cs,
    input  logic [NUM_REQ-1:0]               req_oe,
    input  logic [NUM_REQ-1:0]               req_W_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_W_data,
    output logic [DATA_WIDTH-1:0]            req_R_data,
    output logic                             buffer_cs,
    output logic                             buffer_oe,
    output logic                             buffer_W_req,
    output logic [ADDR_WIDTH-1:0]            buffer_addr,
    output logic [DATA_WIDTH-1:0]            buffer_W_data,
    input  logic [DATA_WIDTH-1:0]            buffer_R_data,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic [1:0]                       dbg_state
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(BURST_SIZE + 1);

    buffer_arbiter_state_t state_q;
    logic [NUM_REQ-1:0]    grant_q;
    logic [IDW-1:0]        grant_id_q;
    logic [IDW-1:0]        pointer_q;
    logic [CNTW-1:0]       tenure_q;

    logic                  owner_req;
    logic                  others_req;
    logic                  tenure_end;
    logic [NUM_REQ-1:0]    exclude;
    logic [NUM_REQ-1:0]    pick_winner;
    logic                  pick_valid;
    logic [IDW-1:0]        win_idx;

    assign owner_req  = |(req_request & grant_q);
    assign others_req = |(req_request & ~grant_q);
    assign tenure_end = !owner_req || (tenure_q == CNTW'(BURST_SIZE));
    // The current owner only competes again when nobody else is asking.
    assign exclude    = others_req ? grant_q : '0;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .request (req_request),
        .pointer (pointer_q),
        .exclude (exclude),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_winner[i]) begin
                win_idx = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_ARB;
            grant_q    <= '0;
            grant_id_q <= '0;
            pointer_q  <= '0;
            tenure_q   <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (pick_valid) begin
                        state_q    <= ST_HOLD;
                        grant_q    <= pick_winner;
                        grant_id_q <= win_idx;
                        pointer_q  <= IDW'(next_ptr(int'(win_idx), NUM_REQ));
                        tenure_q   <= CNTW'(1);
                    end
                end
                ST_HOLD: begin
                    if (!tenure_end) begin
                        tenure_q <= tenure_q + CNTW'(1);
                    end else if (pick_valid) begin
                        // Hand over in the same cycle: no dead cycle between owners.
                        grant_q    <= pick_winner;
                        grant_id_q <= win_idx;
                        pointer_q  <= IDW'(next_ptr(int'(win_idx), NUM_REQ));
                        tenure_q   <= CNTW'(1);
                    end else begin
                        state_q  <= ST_ARB;
                        grant_q  <= '0;
                        tenure_q <= '0;
                    end
                end
                default: begin
                    state_q  <= ST_ARB;
                    grant_q  <= '0;
                    tenure_q <= '0;
                end
            endcase
        end
    end

    assign req_grant  = grant_q;
    assign grant_id   = grant_id_q;
    assign busy       = state_q[HOLD_B];
    assign dbg_state  = state_q;
    assign req_R_data = buffer_R_data;

    // Only the registered owner's pins reach the RAM.
    always_comb begin
        buffer_cs     = CS_DIS;
        buffer_oe     = OE_DIS;
        buffer_W_req  = WREQ_DIS;
        buffer_addr   = '0;
        buffer_W_data = DATA_WIDTH'(EMPTY_DATA);
        if (busy) begin
            buffer_cs     = req_cs[grant_id_q];
            buffer_oe     = req_oe[grant_id_q];
            buffer_W_req  = req_W_req[grant_id_q];
            buffer_addr   = req_addr[grant_id_q*ADDR_WIDTH +: ADDR_WIDTH];
            buffer_W_data = req_W_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buffer_arbiter
// Directed vector table for buffer_arbiter (NUM_REQ=4, BURST_SIZE=4), plus a
// hand-written asynchronous-reset sequence. Follows BUFFER_ARB_FIXED_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_buffer_arbiter;
    import buffer_arbiter_pkg::*;
    import single_port_ram_pkg::*;
    import accelerator_pkg::*;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int BS = 4;

    logic              clk;
    logic              rstn;
    logic [NR-1:0]     req_request;
    logic [NR-1:0]     req_grant;
    logic [NR-1:0]     req_cs;
    logic [NR-1:0]     req_oe;
    logic [NR-1:0]     req_W_req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_W_data;
    logic [DW-1:0]     req_R_data;
    logic              buffer_cs;
    logic              buffer_oe;
    logic              buffer_W_req;
    logic [AW-1:0]     buffer_addr;
    logic [DW-1:0]     buffer_W_data;
    logic [DW-1:0]     buffer_R_data;
    logic              busy;
    logic [1:0]        grant_id;
    logic [1:0]        dbg_state;

    buffer_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BURST_SIZE (BS)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_request   (req_request),
        .req_grant     (req_grant),
        .req_cs        (req_cs),
        .req_oe        (req_oe),
        .req_W_req     (req_W_req),
        .req_addr      (req_addr),
        .req_W_data    (req_W_data),
        .req_R_data    (req_R_data),
        .buffer_cs     (buffer_cs),
        .buffer_oe     (buffer_oe),
        .buffer_W_req  (buffer_W_req),
        .buffer_addr   (buffer_addr),
        .buffer_W_data (buffer_W_data),
        .buffer_R_data (buffer_R_data),
        .busy          (busy),
        .grant_id      (grant_id),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] exp_grant;
    } vec_t;

    vec_t vecs[$];

    logic [AW-1:0] addr_v[NR];
    logic [DW-1:0] wdata_v[NR];
    logic [NR-1:0] cs_v, oe_v, wreq_v;
    logic [DW-1:0] rdata_v;

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic [NR-1:0] r, input logic [NR-1:0] g, input int n);
        vec_t v;
        v.req       = r;
        v.exp_grant = g;
        repeat (n) vecs.push_back(v);
    endtask

    // driver: fresh per-requester RAM pins and read data each cycle
    task automatic drive_data();
        for (int i = 0; i < NR; i++) begin
            addr_v[i]  = AW'($urandom_range(0, (1 << AW) - 1));
            wdata_v[i] = DW'($urandom_range(0, 65535));
            req_addr[i*AW +: AW]  = addr_v[i];
            req_W_data[i*DW +: DW] = wdata_v[i];
        end
        cs_v    = NR'($urandom_range(0, 15));
        oe_v    = NR'($urandom_range(0, 15));
        wreq_v  = NR'($urandom_range(0, 15));
        rdata_v = DW'($urandom_range(0, 65535));
        req_cs        = cs_v;
        req_oe        = oe_v;
        req_W_req     = wreq_v;
        buffer_R_data = rdata_v;
    endtask

    // scoreboard: expected outputs derived from the expected grant
    task automatic check_outputs(input logic [NR-1:0] g, input int row);
        int   id;
        logic b;
        b  = |g;
        id = 0;
        for (int i = 0; i < NR; i++) if (g[i]) id = i;
        check("grant",    row, 32'(req_grant), 32'(g));
        check("busy",     row, 32'(busy), 32'(b));
        check("onehot0",  row, 32'($onehot0(req_grant)), 32'd1);
        check("state",    row, 32'(dbg_state), b ? 32'(ST_HOLD) : 32'(ST_ARB));
        if (b) check("grant_id", row, 32'(grant_id), 32'(id));
        check("buf_cs",   row, 32'(buffer_cs),    b ? 32'(cs_v[id])   : 32'(CS_DIS));
        check("buf_oe",   row, 32'(buffer_oe),    b ? 32'(oe_v[id])   : 32'(OE_DIS));
        check("buf_wreq", row, 32'(buffer_W_req), b ? 32'(wreq_v[id]) : 32'(WREQ_DIS));
        check("buf_addr", row, 32'(buffer_addr),  b ? 32'(addr_v[id]) : 32'd0);
        check("buf_wdat", row, 32'(buffer_W_data), b ? 32'(wdata_v[id]) : 32'(EMPTY_DATA));
        check("r_data",   row, 32'(req_R_data), 32'(rdata_v));
    endtask

    initial begin
        rstn        = 1'b0;
        req_request = '0;
        drive_data();

`ifdef BUFFER_ARB_FIXED_PRIO_EN
        add(4'b1001, 4'b0001, 10);  // 0 re-wins every tenure, 3 starves
        add(4'b1000, 4'b1000, 2);   // 0 drops: 3 granted same edge
        add(4'b1111, 4'b1000, 2);   // 3 finishes its tenure (cnt 3,4)
        add(4'b1111, 4'b0001, 1);   // lowest index wins at tenure end
        add(4'b0000, 4'b0000, 1);
`else
        // all four continuously: 0,1,2,3,0 with 4-cycle tenures
        add(4'b1111, 4'b0001, 4);
        add(4'b1111, 4'b0010, 4);
        add(4'b1111, 4'b0100, 4);
        add(4'b1111, 4'b1000, 4);
        add(4'b1111, 4'b0001, 1);
        add(4'b0000, 4'b0000, 1);
        // pointer=1: owner 1 drops after 2 cycles while 3 requests
        add(4'b1010, 4'b0010, 2);
        add(4'b1000, 4'b1000, 5);   // 4-cycle tenure then re-grant alone
        add(4'b0000, 4'b0000, 1);
        // single requester 2 held: continuous grant across tenure boundaries
        add(4'b0100, 4'b0100, 9);
        add(4'b0000, 4'b0000, 1);
        // simultaneous 0 and 1 with pointer=3: search 3,0 -> 0 first
        add(4'b0011, 4'b0001, 4);
        add(4'b0011, 4'b0010, 4);
        add(4'b0011, 4'b0001, 1);
        add(4'b0000, 4'b0000, 2);
`endif

        // reset values while rstn low
        #12;
        check_outputs('0, -1);
        check("rst_grant_id", -1, 32'(grant_id), 32'd0);

        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            req_request = vecs[i].req;
            drive_data();
            @(posedge clk);
            #1;
            check_outputs(vecs[i].exp_grant, i);
        end

        // asynchronous reset mid-HOLD
        @(negedge clk);
        req_request = 4'b0100;
        drive_data();
        @(posedge clk);
        #1;
        check_outputs(4'b0100, 100);
        @(posedge clk);
        #1;
        check_outputs(4'b0100, 101);
        #2;
        rstn = 1'b0;
        #1;
        check_outputs('0, 102);
        check("rst_grant_id", 102, 32'(grant_id), 32'd0);
        // release with 1,2,3 requesting: pointer back at 0 -> requester 1
        @(negedge clk);
        rstn        = 1'b1;
        req_request = 4'b1110;
        drive_data();
        @(posedge clk);
        #1;
        check_outputs(4'b0010, 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
